ext_decoder_drv: RTL and testbench

- Registered 4-to-16 decoder/driver; the opposite direction of the team's 16-to-4 extended priority encoder.
- Takes a 4-bit code and drives two active-low one-hot bytes, {DataOut, DataOut_0}, in the same format the encoder consumes as {DataIn, DataIn_0}.
- Mirrors the decoded code on an active-low 7-segment digit.
- Sweep mode auto-generates the 17-step walking-zero pattern (16 one-hot steps + idle step), so the encoder can be exercised on the board without a host.

---
 rtl/ext_coder_pkg.sv | 42 ++++
 rtl/seg7_hex.sv | 15 +
 rtl/ext_decoder_drv.sv | 160 ++++++++++++++++
 tb/tb_ext_decoder_drv.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ext_coder_pkg.sv
// ext_coder_pkg -- shared types and constants for the extended 4<->16 coder
// blocks.
//   state_t     : decoder/driver FSM states
//   SEG_BLANK   : active-low 7-segment pattern with every segment off
//   IDLE_BYTE   : active-low one-hot byte with no bit asserted
//   hex_to_seg  : 4-bit value -> active-low {dp,g,f,e,d,c,b,a}, dp off
package ext_coder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    SWEEP = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] IDLE_BYTE = 8'hFF;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
    logic [7:0] seg;
    case (hex)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex.sv
// seg7_hex -- combinational hex digit to active-low 7-segment pattern.
//   hex   : digit to show (0..F)
//   blank : 1 forces all segments off
//   seg   : active-low {dp,g,f,e,d,c,b,a}; the parent registers it
module seg7_hex
  import ext_coder_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       blank,
  output logic [7:0] seg
);

  assign seg = blank ? SEG_BLANK : hex_to_seg(hex);

endmodule

// File: rtl/ext_decoder_drv.sv
// ext_decoder_drv -- registered 4-to-16 active-low one-hot decoder/driver
// with a mirrored 7-segment digit and a free-running sweep mode that walks a
// single low bit across all 16 positions followed by one idle step.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   code        : direct code to drive (0..15)
//   code_valid  : direct request strobe, taken when code_ready is high
//   code_ready  : IDLE and mode == 0 (the only combinational output)
//   mode        : 0 = direct requests, 1 = sweep
//   DataOut     : active-low one-hot for codes 15..8 (bit7 = code 15)
//   DataOut_0   : active-low one-hot for codes 7..0 (bit0 = code 0)
//   Active      : a one-hot bit is currently driven low
//   Seg         : active-low {dp,g,f,e,d,c,b,a} showing the driven code
//   sweep_done  : one-cycle pulse on the last cycle of each sweep pass
module ext_decoder_drv
  import ext_coder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int STEP_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] code,
  input  logic       code_valid,
  output logic       code_ready,
  input  logic       mode,
  output logic [7:0] DataOut,
  output logic [7:0] DataOut_0,
  output logic       Active,
  output logic [7:0] Seg,
  output logic       sweep_done
);

  localparam int HW = $clog2(HOLD_CYCLES < 2 ? 2 : HOLD_CYCLES);
  localparam int SW = $clog2(STEP_CYCLES < 2 ? 2 : STEP_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LOAD = SW'(STEP_CYCLES - 1);

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] step_cnt;
  logic [3:0]    idx;        // held code in HOLD, sweep index in SWEEP

  // What the output registers will show after the coming edge.
  logic          show_en;
  logic [3:0]    show_code;
  logic [7:0]    seg_next;

  assign code_ready = (state == IDLE) && !mode;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    show_en   = 1'b0;
    show_code = idx;
    case (state)
      IDLE: begin
        if (mode) begin
          show_en   = 1'b1;
          show_code = 4'd0;
        end else if (code_valid) begin
          show_en   = 1'b1;
          show_code = code;
        end
      end
      HOLD:  show_en = (hold_cnt != '0);
      SWEEP: begin
        if (step_cnt != '0) begin
          show_en = 1'b1;
        end else if (idx != 4'd15) begin
          show_en   = 1'b1;
          show_code = 4'(idx + 4'd1);
        end
      end
      GAP: begin
        if (step_cnt == '0 && mode) begin
          show_en   = 1'b1;
          show_code = 4'd0;
        end
      end
      default: show_en = 1'b0;
    endcase
  end

  seg7_hex u_seg (
    .hex   (show_code),
    .blank (!show_en),
    .seg   (seg_next)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      step_cnt   <= '0;
      idx        <= '0;
      DataOut    <= IDLE_BYTE;
      DataOut_0  <= IDLE_BYTE;
      Seg        <= SEG_BLANK;
      Active     <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      {DataOut, DataOut_0} <= show_en ? ~(16'd1 << show_code)
                                      : {IDLE_BYTE, IDLE_BYTE};
      Seg        <= seg_next;
      Active     <= show_en;
      sweep_done <= 1'b0;

      case (state)
        IDLE: begin
          if (mode) begin
            state    <= SWEEP;
            idx      <= 4'd0;
            step_cnt <= STEP_LOAD;
          end else if (code_valid) begin
            state    <= HOLD;
            idx      <= code;
            hold_cnt <= HOLD_LOAD;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) state <= IDLE;
          else                hold_cnt <= hold_cnt - HW'(1);
        end
        SWEEP: begin
          if (step_cnt == '0) begin
            step_cnt <= STEP_LOAD;
            if (idx == 4'd15) begin
              state      <= GAP;
              // A single-cycle gap is its own last cycle.
              sweep_done <= (STEP_LOAD == '0);
            end else begin
              idx <= 4'(idx + 4'd1);
            end
          end else begin
            step_cnt <= step_cnt - SW'(1);
          end
        end
        GAP: begin
          if (step_cnt == '0) begin
            // mode is only sampled here, so a pass always runs to completion.
            if (mode) begin
              state    <= SWEEP;
              idx      <= 4'd0;
              step_cnt <= STEP_LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            step_cnt   <= step_cnt - SW'(1);
            sweep_done <= (step_cnt == SW'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_decoder_drv.sv
// tb_ext_decoder_drv -- directed bench for ext_decoder_drv with
// HOLD_CYCLES = 4 and STEP_CYCLES = 20, including a behavioural model of the
// 16-to-4 encoder fed from the driver outputs.
module tb_ext_decoder_drv;

  localparam int HOLD = 4;
  localparam int STEP = 20;
  localparam int PASS = 17 * STEP;

  logic       clk;
  logic       rst_n;
  logic [3:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       mode;
  logic [7:0] DataOut;
  logic [7:0] DataOut_0;
  logic       Active;
  logic [7:0] Seg;
  logic       sweep_done;

  int total = 0;
  int bad   = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  ext_decoder_drv #(.HOLD_CYCLES(HOLD), .STEP_CYCLES(STEP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .mode       (mode),
    .DataOut    (DataOut),
    .DataOut_0  (DataOut_0),
    .Active     (Active),
    .Seg        (Seg),
    .sweep_done (sweep_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Encoder model: {valid, code} when exactly one bit is low, else 0.
  function automatic logic [4:0] enc(input logic [15:0] w);
    int zeros = 0;
    logic [3:0] pos = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (!w[i]) begin
        zeros++;
        pos = 4'(i);
      end
    end
    return (zeros == 1) ? {1'b1, pos} : 5'd0;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_hi"},  DataOut,    8'hFF);
    check({tag, "_lo"},  DataOut_0,  8'hFF);
    check({tag, "_seg"}, Seg,        8'hFF);
    check({tag, "_act"}, Active,     1'b0);
  endtask

  // One direct request, held HOLD cycles, then back to idle.
  task automatic direct(input logic [3:0] c, input logic [7:0] hi, input logic [7:0] lo,
                        input logic [7:0] sg);
    check("dir_ready_pre", code_ready, 1'b1);
    code       = c;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      check("dir_hi",    DataOut,    hi);
      check("dir_lo",    DataOut_0,  lo);
      check("dir_seg",   Seg,        sg);
      check("dir_act",   Active,     1'b1);
      check("dir_ready", code_ready, 1'b0);
      tick();
    end
    check_idle("dir_end");
    check("dir_ready_post", code_ready, 1'b1);
  endtask

  initial begin
    logic [15:0] one;
    logic [15:0] exp_w;
    logic [4:0]  e;
    int          p;
    int          st;
    int          pulses;

    one        = 16'd1;
    rst_n      = 1'b0;
    code       = 4'd0;
    code_valid = 1'b0;
    mode       = 1'b0;

    // Reset state.
    repeat (2) tick();
    check_idle("rst");
    check("rst_done",  sweep_done, 1'b0);
    check("rst_ready", code_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Direct requests at both ends and in the middle.
    direct(4'd0,  8'hFF, 8'hFE, 8'hC0);
    tick();
    direct(4'd15, 8'h7F, 8'hFF, 8'h8E);
    direct(4'd6,  8'hFF, 8'hBF, 8'h82);
    direct(4'd10, 8'hFB, 8'hFF, 8'h88);

    // Request while busy is dropped; re-accept on the first IDLE cycle.
    code       = 4'd3;
    code_valid = 1'b1;
    tick();
    code = 4'd5;
    for (int i = 0; i < HOLD; i++) begin
      check("busy_lo",    DataOut_0,  8'hF7);
      check("busy_seg",   Seg,        8'hB0);
      check("busy_ready", code_ready, 1'b0);
      tick();
    end
    check_idle("busy_gap");
    check("busy_gap_ready", code_ready, 1'b1);
    tick();
    code_valid = 1'b0;
    check("reacc_lo",  DataOut_0, 8'hDF);
    check("reacc_seg", Seg,       8'h92);
    check("reacc_act", Active,    1'b1);
    repeat (HOLD) tick();
    check_idle("reacc_end");

    // Asynchronous reset in the middle of a HOLD showing code 9.
    code       = 4'd9;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    tick();
    check("pre_rst_hi", DataOut, 8'hFD);
    check("pre_rst_seg", Seg,    8'h90);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_ready", code_ready, 1'b1);
    tick();
    check_idle("rst_hold");
    rst_n = 1'b1;
    tick();
    check_idle("post_rst");

    // Two sweep passes with the encoder model on the outputs; mode drops
    // at index 7 of the second pass so it ends in IDLE.
    mode   = 1'b1;
    pulses = 0;
    tick();
    for (int n = 0; n < 2 * PASS; n++) begin
      p  = n % PASS;
      st = p / STEP;
      e  = enc({DataOut, DataOut_0});
      if (st < 16) begin
        exp_w = ~(one << st);
        check("sw_word", {DataOut, DataOut_0}, exp_w);
        check("sw_seg",  Seg,    seg_tab[st]);
        check("sw_act",  Active, 1'b1);
        check("loop_code", e, {1'b1, 4'(st)});
      end else begin
        check("gap_word", {DataOut, DataOut_0}, 16'hFFFF);
        check("gap_seg",  Seg,    8'hFF);
        check("gap_act",  Active, 1'b0);
        check("loop_gap", e[4],   1'b0);
      end
      check("sw_done",  sweep_done, (p == PASS - 1) ? 1'b1 : 1'b0);
      check("sw_ready", code_ready, 1'b0);
      if (sweep_done && n < PASS) pulses++;
      if (n >= PASS && st == 7 && (p % STEP) == 0) mode = 1'b0;
      tick();
    end
    check("done_count", pulses, 1);
    check_idle("sw_exit");
    check("sw_exit_ready", code_ready, 1'b1);
    check("sw_exit_done",  sweep_done, 1'b0);
    repeat (STEP + 5) tick();
    check_idle("sw_stay_idle");

    // Direct mode works again after the sweep.
    direct(4'd1, 8'hFF, 8'hFD, 8'hF9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
